// File: rtl/c_reg_ld_arb_pkg.sv
// Shared definitions for the load-register arbiter.
// Holds the FSM state encoding, the opcode encodings carried on REQ_OP,
// the settle-counter width and a helper that sizes requester indices.
package c_reg_ld_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_GATE   = 2'b01,
      ST_SETTLE = 2'b10
   } state_e;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_SCLR  = 2'b01;
   localparam logic [1:0] OP_SSET  = 2'b10;
   localparam logic [1:0] OP_SINIT = 2'b11;

   // Settle hold is at most 7 cycles, so three bits suffice.
   localparam int CNT_W = 3;

   // Width of an index able to address n requesters (never below 1 bit).
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/c_rr_pick.sv
// Round-robin picker.
// Ports: req_i  - request vector
//        ptr_i  - index with highest priority this round
//        gnt_o  - one-hot grant (all 0 when no request)
//        idx_o  - binary index of the granted requester
//        vld_o  - a grant was made
module c_rr_pick
   import c_reg_ld_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          vld_o
);

   logic [IW-1:0] pos_s;

   // Scan from the pointer upward with wrap; first requester seen wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      pos_s = '0;
      for (int k = 0; k < N; k++) begin
         pos_s = IW'((int'(ptr_i) + k) % N);
         if (!vld_o && req_i[pos_s]) begin
            vld_o        = 1'b1;
            gnt_o[pos_s] = 1'b1;
            idx_o        = pos_s;
         end else begin
            vld_o = vld_o;
         end
      end
   end

endmodule

// File: rtl/c_reg_ld_arb_v5_0.sv
// Arbiter granting requesters access to a bank of shared load-registers.
// A winner's select/opcode/data are captured, the gate of the addressed
// register is pulsed for one cycle with data and strobe, the bus is held
// for C_SETTLE cycles and the winner is acknowledged.
// Ports: CLK, ARESET_N (async active-low)
//        REQ/REQ_SEL/REQ_OP/REQ_D - packed per-requester request fields
//        ACK, ERR, BUSY           - completion, bad-select flag, activity
//        LD_G, LD_D               - register gates and shared data bus
//        LD_SCLR/LD_SSET/LD_SINIT - shared synchronous-control strobes
module c_reg_ld_arb_v5_0
   import c_reg_ld_arb_pkg::*;
#(
   parameter int C_NUM_REQ   = 4,
   parameter int C_NUM_REG   = 4,
   parameter int C_SEL_WIDTH = 2,
   parameter int C_WIDTH     = 16,
   parameter int C_SETTLE    = 1
) (
   input  logic                             CLK,
   input  logic                             ARESET_N,
   input  logic [C_NUM_REQ-1:0]             REQ,
   input  logic [C_NUM_REQ*C_SEL_WIDTH-1:0] REQ_SEL,
   input  logic [C_NUM_REQ*2-1:0]           REQ_OP,
   input  logic [C_NUM_REQ*C_WIDTH-1:0]     REQ_D,
   output logic [C_NUM_REQ-1:0]             ACK,
   output logic                             ERR,
   output logic                             BUSY,
   output logic [C_NUM_REG-1:0]             LD_G,
   output logic [C_WIDTH-1:0]               LD_D,
   output logic                             LD_SCLR,
   output logic                             LD_SSET,
   output logic                             LD_SINIT
);

   localparam int IW = idx_w(C_NUM_REQ);

   state_e                 state_q, state_d;
   logic [IW-1:0]          ptr_q, ptr_d;
   logic [C_NUM_REQ-1:0]   win_q, win_d;
   logic                   oob_q, oob_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [C_NUM_REQ-1:0]   ack_q, ack_d;
   logic                   err_q, err_d;
   logic                   busy_q, busy_d;
   logic [C_NUM_REG-1:0]   ld_g_q, ld_g_d;
   logic [C_WIDTH-1:0]     ld_d_q, ld_d_d;
   logic                   sclr_q, sclr_d;
   logic                   sset_q, sset_d;
   logic                   sinit_q, sinit_d;

   logic [C_NUM_REQ-1:0]   gnt_s;
   logic [IW-1:0]          idx_s;
   logic                   vld_s;
   logic [C_SEL_WIDTH-1:0] sel_s;
   logic [1:0]             op_s;
   logic [C_WIDTH-1:0]     dat_s;
   logic                   oob_s;

   c_rr_pick #(
      .N  (C_NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req_i (REQ),
      .ptr_i (ptr_q),
      .gnt_o (gnt_s),
      .idx_o (idx_s),
      .vld_o (vld_s)
   );

   // One-hot AND-OR mux of the winner's request fields.
   always_comb begin
      sel_s = '0;
      op_s  = '0;
      dat_s = '0;
      for (int i = 0; i < C_NUM_REQ; i++) begin
         sel_s = sel_s | ({C_SEL_WIDTH{gnt_s[i]}} & REQ_SEL[i*C_SEL_WIDTH +: C_SEL_WIDTH]);
         op_s  = op_s  | ({2{gnt_s[i]}}           & REQ_OP[i*2 +: 2]);
         dat_s = dat_s | ({C_WIDTH{gnt_s[i]}}     & REQ_D[i*C_WIDTH +: C_WIDTH]);
      end
      oob_s = (32'(sel_s) >= 32'(C_NUM_REG));
   end

   // Next-state and next-output logic; outputs are precomputed one cycle
   // ahead so every port comes straight from a flop.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      oob_d   = oob_q;
      cnt_d   = cnt_q;
      ack_d   = '0;
      err_d   = 1'b0;
      ld_g_d  = '0;
      ld_d_d  = ld_d_q;
      sclr_d  = 1'b0;
      sset_d  = 1'b0;
      sinit_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (vld_s) begin
               state_d = ST_GATE;
               win_d   = gnt_s;
               oob_d   = oob_s;
               if (32'(idx_s) == 32'(C_NUM_REQ - 1)) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = idx_s + IW'(1);
               end
               // An out-of-range select matches no bit, leaving all gates low.
               for (int r = 0; r < C_NUM_REG; r++) begin
                  ld_g_d[r] = (32'(sel_s) == 32'(r));
               end
               ld_d_d  = (op_s == OP_LOAD) ? dat_s : '0;
               sclr_d  = (op_s == OP_SCLR);
               sset_d  = (op_s == OP_SSET);
               sinit_d = (op_s == OP_SINIT);
               if (C_SETTLE == 0) begin
                  ack_d = gnt_s;
                  err_d = oob_s;
               end else begin
                  ack_d = '0;
                  err_d = 1'b0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GATE: begin
            if (C_SETTLE == 0) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_SETTLE;
               cnt_d   = CNT_W'(C_SETTLE - 1);
               // With a single settle cycle that cycle is also the ACK cycle.
               if (C_SETTLE == 1) begin
                  ack_d = win_q;
                  err_d = oob_q;
               end else begin
                  ack_d = '0;
                  err_d = 1'b0;
               end
            end
         end
         ST_SETTLE: begin
            if (cnt_q == 3'd0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  ack_d = win_q;
                  err_d = oob_q;
               end else begin
                  ack_d = '0;
                  err_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset aborts any operation silently.
   always_ff @(posedge CLK or negedge ARESET_N) begin
      if (!ARESET_N) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         oob_q   <= 1'b0;
         cnt_q   <= '0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         ld_g_q  <= '0;
         ld_d_q  <= '0;
         sclr_q  <= 1'b0;
         sset_q  <= 1'b0;
         sinit_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         oob_q   <= oob_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         ld_g_q  <= ld_g_d;
         ld_d_q  <= ld_d_d;
         sclr_q  <= sclr_d;
         sset_q  <= sset_d;
         sinit_q <= sinit_d;
      end
   end

   assign ACK      = ack_q;
   assign ERR      = err_q;
   assign BUSY     = busy_q;
   assign LD_G     = ld_g_q;
   assign LD_D     = ld_d_q;
   assign LD_SCLR  = sclr_q;
   assign LD_SSET  = sset_q;
   assign LD_SINIT = sinit_q;

endmodule

// File: tb/tb_c_reg_ld_arb_v5_0.sv
// Self-checking bench: instance A uses default parameters, instance B uses
// C_NUM_REG=3 and C_SETTLE=0 for the bad-select and back-to-back cases.
module tb_c_reg_ld_arb_v5_0;

   logic CLK = 1'b0;
   logic ARESET_N;

   logic [3:0]  a_req;
   logic [7:0]  a_sel;
   logic [7:0]  a_op;
   logic [63:0] a_d;
   logic [3:0]  a_ack;
   logic        a_err, a_busy, a_sclr, a_sset, a_sinit;
   logic [3:0]  a_ldg;
   logic [15:0] a_ldd;

   logic [3:0]  b_req;
   logic [7:0]  b_sel;
   logic [7:0]  b_op;
   logic [63:0] b_d;
   logic [3:0]  b_ack;
   logic        b_err, b_busy, b_sclr, b_sset, b_sinit;
   logic [2:0]  b_ldg;
   logic [15:0] b_ldd;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   c_reg_ld_arb_v5_0 #(
      .C_NUM_REQ(4), .C_NUM_REG(4), .C_SEL_WIDTH(2), .C_WIDTH(16), .C_SETTLE(1)
   ) dut_a (
      .CLK(CLK), .ARESET_N(ARESET_N),
      .REQ(a_req), .REQ_SEL(a_sel), .REQ_OP(a_op), .REQ_D(a_d),
      .ACK(a_ack), .ERR(a_err), .BUSY(a_busy),
      .LD_G(a_ldg), .LD_D(a_ldd),
      .LD_SCLR(a_sclr), .LD_SSET(a_sset), .LD_SINIT(a_sinit)
   );

   c_reg_ld_arb_v5_0 #(
      .C_NUM_REQ(4), .C_NUM_REG(3), .C_SEL_WIDTH(2), .C_WIDTH(16), .C_SETTLE(0)
   ) dut_b (
      .CLK(CLK), .ARESET_N(ARESET_N),
      .REQ(b_req), .REQ_SEL(b_sel), .REQ_OP(b_op), .REQ_D(b_d),
      .ACK(b_ack), .ERR(b_err), .BUSY(b_busy),
      .LD_G(b_ldg), .LD_D(b_ldd),
      .LD_SCLR(b_sclr), .LD_SSET(b_sset), .LD_SINIT(b_sinit)
   );

   typedef struct {
      logic [3:0]  req;
      logic [7:0]  sel;   // {s3,s2,s1,s0}
      logic [7:0]  op;    // {o3,o2,o1,o0}
      logic [63:0] d;     // {d3,d2,d1,d0}
      logic [3:0]  g;     // expected LD_G in GATE
      logic [15:0] ldd;   // expected LD_D in GATE/SETTLE
      logic [2:0]  strb;  // expected {SCLR,SSET,SINIT} in GATE
      logic [3:0]  ack;   // expected ACK in SETTLE
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      logic [3:0] exp_ack;
      logic [3:0] exp_g;
      logic [2:0] exp_bg;

      // Pointer starts at 0; each row's winner follows from the previous one.
      tbl[0] = '{4'b0001, 8'b01_11_00_10, 8'b01_10_11_00,
                 {16'h3333, 16'h2222, 16'h1111, 16'hA5A5},
                 4'b0100, 16'hA5A5, 3'b000, 4'b0001};
      tbl[1] = '{4'b0101, 8'b00_01_11_10, 8'b00_01_10_11,
                 {16'h4444, 16'h1234, 16'h5555, 16'h6666},
                 4'b0010, 16'h0000, 3'b100, 4'b0100};
      tbl[2] = '{4'b0011, 8'b01_10_00_11, 8'b00_00_01_10,
                 {16'h1357, 16'h2468, 16'h0A0A, 16'hFFFF},
                 4'b1000, 16'h0000, 3'b010, 4'b0001};
      tbl[3] = '{4'b0100, 8'b11_00_01_10, 8'b00_11_00_00,
                 {16'h1111, 16'hBEEF, 16'h2222, 16'h3333},
                 4'b0001, 16'h0000, 3'b001, 4'b0100};
      tbl[4] = '{4'b1111, 8'b01_00_10_11, 8'b00_01_10_11,
                 {16'h0F0F, 16'h7070, 16'h5A5A, 16'hC3C3},
                 4'b0010, 16'h0F0F, 3'b000, 4'b1000};
      tbl[5] = '{4'b1010, 8'b00_01_11_10, 8'b01_10_00_11,
                 {16'h7777, 16'h8888, 16'h8001, 16'h9999},
                 4'b1000, 16'h8001, 3'b000, 4'b0010};

      a_req = '0; a_sel = '0; a_op = '0; a_d = '0;
      b_req = '0; b_sel = '0; b_op = '0; b_d = '0;
      ARESET_N = 1'b0;

      repeat (2) @(posedge CLK);
      #1;
      chk("rst_a_ldg", a_ldg, 4'b0000);
      chk("rst_a_ldd", a_ldd, 16'h0000);
      chk("rst_a_ctl", {a_ack, a_err, a_busy, a_sclr, a_sset, a_sinit}, 9'b0);
      chk("rst_b_ctl", {b_ack, b_err, b_busy, b_ldg, b_sclr, b_sset, b_sinit}, 12'b0);

      @(negedge CLK);
      ARESET_N = 1'b1;
      @(posedge CLK);
      #1;

      // Table: one full transaction per row, REQ dropped in the ACK cycle.
      for (int i = 0; i < 6; i++) begin
         a_req = tbl[i].req; a_sel = tbl[i].sel; a_op = tbl[i].op; a_d = tbl[i].d;
         @(posedge CLK); #1;
         chk($sformatf("v%0d_gate_ldg", i), a_ldg, tbl[i].g);
         chk($sformatf("v%0d_gate_ldd", i), a_ldd, tbl[i].ldd);
         chk($sformatf("v%0d_gate_strb", i), {a_sclr, a_sset, a_sinit}, tbl[i].strb);
         chk($sformatf("v%0d_gate_ack_busy", i), {a_ack, a_busy}, 5'b0000_1);
         @(posedge CLK); #1;
         chk($sformatf("v%0d_set_ldg_strb", i), {a_ldg, a_sclr, a_sset, a_sinit}, 7'b0);
         chk($sformatf("v%0d_set_ldd", i), a_ldd, tbl[i].ldd);
         chk($sformatf("v%0d_set_ack", i), a_ack, tbl[i].ack);
         chk($sformatf("v%0d_set_err_busy", i), {a_err, a_busy}, 2'b01);
         a_req = '0;
         @(posedge CLK); #1;
         chk($sformatf("v%0d_idle", i), {a_ack, a_busy, a_err}, 6'b0);
      end

      // In-flight capture must ignore input changes while busy (pointer = 2).
      a_req = 4'b0100; a_sel = 8'b11_01_00_00; a_op = 8'b11_00_00_00;
      a_d = {16'h1111, 16'hCAFE, 16'h2222, 16'h3333};
      @(posedge CLK); #1;
      chk("hold_gate_ldg", a_ldg, 4'b0010);
      chk("hold_gate_ldd", a_ldd, 16'hCAFE);
      a_req = 4'b1111; a_sel = 8'hFF; a_op = 8'hFF; a_d = {4{16'hFFFF}};
      @(posedge CLK); #1;
      chk("hold_set_ldd", a_ldd, 16'hCAFE);
      chk("hold_set_ack", a_ack, 4'b0100);
      // Next: IDLE, then requester 3 (sel 3, sinit) is granted.
      @(posedge CLK); #1;
      chk("hold_idle_busy", a_busy, 1'b0);
      @(posedge CLK); #1;
      chk("r3_gate_ldg", a_ldg, 4'b1000);
      chk("r3_gate_sinit", {a_sclr, a_sset, a_sinit, a_ldd}, {3'b001, 16'h0000});

      // Reset during GATE: outputs drop at once and no ACK follows.
      #2;
      ARESET_N = 1'b0;
      #1;
      chk("rst_gate_ldg", a_ldg, 4'b0000);
      chk("rst_gate_ctl", {a_busy, a_sinit, a_ack}, 6'b0);
      a_sel = 8'b01_01_01_01; a_op = 8'h00;
      a_d = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
      for (int c = 0; c < 2; c++) begin
         @(posedge CLK); #1;
         chk("rst_hold_noack", {a_ack, a_ldg, a_busy}, 9'b0);
      end
      @(negedge CLK);
      ARESET_N = 1'b1;

      // All four held: grants 0,1,2,3,0 every three cycles.
      for (int c = 1; c <= 14; c++) begin
         @(posedge CLK); #1;
         exp_g   = ((c % 3) == 1) ? 4'b0010 : 4'b0000;
         exp_ack = ((c % 3) == 2) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
         chk($sformatf("rr_c%0d_ldg", c), a_ldg, exp_g);
         chk($sformatf("rr_c%0d_ack", c), a_ack, exp_ack);
         if ((c % 3) == 1) begin
            chk($sformatf("rr_c%0d_ldd", c), a_ldd, 16'hD000 + 16'((c / 3) % 4));
         end else begin
            chk($sformatf("rr_c%0d_err", c), a_err, 1'b0);
         end
      end
      a_req = '0;
      repeat (2) @(posedge CLK);
      #1;

      // Instance B: select 3 with only 3 registers -> no gate, ERR with ACK.
      b_req = 4'b0001; b_sel = 8'b00_10_00_11; b_op = 8'h00;
      b_d = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      @(posedge CLK); #1;
      chk("oob_ldg", b_ldg, 3'b000);
      chk("oob_ack", b_ack, 4'b0001);
      chk("oob_err_busy", {b_err, b_busy}, 2'b11);
      b_req = '0;
      @(posedge CLK); #1;
      chk("oob_after", {b_ack, b_err, b_busy}, 6'b0);

      // Instance B: requesters 1 and 2 held, ACK every 2 cycles alternating.
      b_req = 4'b0110; b_sel = 8'b00_10_00_00;
      for (int c = 1; c <= 8; c++) begin
         @(posedge CLK); #1;
         if ((c % 2) == 1) begin
            exp_ack = ((((c - 1) / 2) % 2) == 0) ? 4'b0010 : 4'b0100;
            exp_bg  = ((((c - 1) / 2) % 2) == 0) ? 3'b001 : 3'b100;
         end else begin
            exp_ack = 4'b0000;
            exp_bg  = 3'b000;
         end
         chk($sformatf("s0_c%0d_ack", c), b_ack, exp_ack);
         chk($sformatf("s0_c%0d_ldg", c), b_ldg, exp_bg);
         chk($sformatf("s0_c%0d_err", c), b_err, 1'b0);
      end
      b_req = '0;
      @(posedge CLK); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
